// File: rtl/cpu_out_uart_tx.sv
// CPU output word queue feeding an 8N1 UART, low byte then high byte; tx falls one edge after a push into an idle, empty queue.
// No backpressure: pushes into a full queue are dropped and latched in the sticky overflow flag.
module cpu_out_uart_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              data_in,
  input  logic                     data_valid,
  input  logic                     overflow_clr,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int BM = CLKS_PER_BIT - 1;
  localparam logic [AW:0]   FULL     = DEPTH[AW:0];
  localparam logic [BW-1:0] BAUD_MAX = BM[BW-1:0];

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d, next_bit;
  logic          hb_q, hb_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          push, pop;
  logic [7:0]    cur_byte;

  assign cur_byte = hb_q ? shadow_q[15:8] : shadow_q[7:0];

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    hb_d     = hb_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    pop      = 1'b0;
    next_bit = bit_q + 3'd1;

    // tx_d always carries the level of the state/bit being entered, so tx stays registered
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop      = 1'b1;
          shadow_d = mem_q[rd_ptr_q];
          hb_d     = 1'b0;
          state_d  = START;
          baud_d   = BAUD_MAX;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_MAX;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = next_bit;
            tx_d  = cur_byte[next_bit];
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!hb_q) begin
            hb_d    = 1'b1;
            state_d = START;
            baud_d  = BAUD_MAX;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // fullness is judged before this cycle's pop, so a pop never makes room for a same-cycle push
    push     = data_valid && (count_q != FULL);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push && pop) count_d = count_q - (AW+1)'(1);

    if (data_valid && (count_q == FULL)) overflow_d = 1'b1;
    else if (overflow_clr)               overflow_d = 1'b0;
    else                                 overflow_d = overflow_q;

    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      hb_q       <= 1'b0;
      shadow_q   <= 16'h0000;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      hb_q       <= hb_d;
      shadow_q   <= shadow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_out_uart_tx.sv
// Directed bench for cpu_out_uart_tx at DEPTH=4, CLKS_PER_BIT=4.
module tb_cpu_out_uart_tx;

  logic        clk;
  logic        reset;
  logic [15:0] data_in;
  logic        data_valid;
  logic        overflow_clr;
  logic        tx;
  logic        busy;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  cpu_out_uart_tx #(.DEPTH(4), .CLKS_PER_BIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .overflow_clr (overflow_clr),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_bits(input logic [15:0] w);
    logic [19:0] e;
    e[0]     = 1'b0;
    e[8:1]   = w[7:0];
    e[9]     = 1'b1;
    e[10]    = 1'b0;
    e[18:11] = w[15:8];
    e[19]    = 1'b1;
    return e;
  endfunction

  // Called just after the edge where tx fell; returns just after the last stop-bit cycle.
  task automatic frame(input logic [15:0] w, input string name);
    logic [79:0] s;
    logic [19:0] e;
    logic [15:0] got;
    logic        ok;
    e    = exp_bits(w);
    s[0] = tx;
    for (int i = 1; i < 80; i++) begin
      tick();
      s[i] = tx;
    end
    ok = 1'b1;
    for (int i = 0; i < 80; i++) if (s[i] !== e[i/4]) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      got[k]   = s[4*(k+1)+2];
      got[8+k] = s[4*(k+11)+2];
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL %s_wave: samples %h, required bit pattern %h", name, s, e);
    else n_pass++;
    n_checks++;
    if (got !== w) $display("FAIL %s_word: decoded %h, required %h", name, got, w);
    else n_pass++;
  endtask

  task automatic do_reset();
    reset = 1'b0; data_valid = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic ok;
    reset = 1'b0; data_valid = 1'b0; overflow_clr = 1'b0; data_in = 16'h0000;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_valid = ~data_valid;
      data_in    = 16'h1111 * i[15:0];
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) ok = 1'b0;
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL reset_hold: outputs left idle while reset low (tx=%b busy=%b cnt=%0d ov=%b)", tx, busy, fifo_count, overflow);
    else n_pass++;
    data_valid = 1'b0;
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (tx !== 1'b1)         $display("FAIL rel_tx: got %b, required 1", tx);          else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL rel_busy: got %b, required 0", busy);      else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL rel_cnt: got %0d, required 0", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0)   $display("FAIL rel_ov: got %b, required 0", overflow);    else n_pass++;
  endtask

  task automatic test_single();
    data_in = 16'hA53C; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; data_in = 16'hDEAD;
    n_checks++; if (busy !== 1'b1)       $display("FAIL single_busy_rise: got %b, required 1", busy);  else n_pass++;
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL single_cnt1: got %0d, required 1", fifo_count); else n_pass++;
    n_checks++; if (tx !== 1'b1)         $display("FAIL single_tx_pre: got %b, required 1", tx);       else n_pass++;
    tick();
    n_checks++; if (tx !== 1'b0)         $display("FAIL single_tx_fall: got %b, required 0", tx);      else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL single_cnt0: got %0d, required 0", fifo_count); else n_pass++;
    frame(16'hA53C, "single");
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b, required 0", busy); else n_pass++;
    n_checks++; if (tx !== 1'b1)   $display("FAIL single_tx_idle: got %b, required 1", tx);     else n_pass++;
  endtask

  task automatic test_back_to_back();
    data_in = 16'h0001; data_valid = 1'b1;
    tick();
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL b2b_cnt_a: got %0d, required 1", fifo_count); else n_pass++;
    data_in = 16'hFFFF;
    tick();
    data_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) $display("FAIL b2b_cnt_b: got %0d, required 1", fifo_count); else n_pass++;
    frame(16'h0001, "b2b_first");
    tick();
    n_checks++; if (tx !== 1'b1) $display("FAIL b2b_gap_high: got %b, required 1", tx); else n_pass++;
    tick();
    n_checks++; if (tx !== 1'b0) $display("FAIL b2b_second_start: got %b, required 0", tx); else n_pass++;
    frame(16'hFFFF, "b2b_second");
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_busy_fall: got %b, required 0", busy); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] ws [7];
    ws = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006, 16'h7007};
    data_in = ws[0]; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    fork
      frame(ws[0], "ov_w0");
      begin
        for (int k = 0; k < 6; k++) begin
          data_valid = 1'b1; data_in = ws[k+1];
          tick();
          n_checks++;
          if (fifo_count !== ((k < 4) ? 3'(k + 1) : 3'd4))
            $display("FAIL ov_cnt_%0d: got %0d, required %0d", k, fifo_count, (k < 4) ? k + 1 : 4);
          else n_pass++;
          n_checks++;
          if (overflow !== ((k >= 4) ? 1'b1 : 1'b0))
            $display("FAIL ov_flag_%0d: got %b, required %b", k, overflow, (k >= 4));
          else n_pass++;
        end
        data_valid = 1'b0;
      end
    join
    for (int j = 1; j <= 4; j++) begin
      tick();
      n_checks++; if (tx !== 1'b1) $display("FAIL ov_gap_%0d: got %b, required 1", j, tx); else n_pass++;
      tick();
      frame(ws[j], $sformatf("ov_w%0d", j));
    end
    tick();
    n_checks++; if (busy !== 1'b0)     $display("FAIL ov_drained_busy: got %b, required 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ov_sticky: got %b, required 1", overflow);   else n_pass++;
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ov_clr: got %b, required 0", overflow); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    do_reset();
    data_in = 16'hC000; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int k = 1; k <= 4; k++) begin
      data_valid = 1'b1; data_in = 16'hC000 + k[15:0];
      tick();
    end
    data_valid = 1'b0;
    repeat (76) tick();
    n_checks++; if (fifo_count !== 3'd4 || tx !== 1'b1 || busy !== 1'b1)
      $display("FAIL ppf_pre: cnt=%0d tx=%b busy=%b, required cnt=4 tx=1 busy=1", fifo_count, tx, busy);
    else n_pass++;
    data_valid = 1'b1; data_in = 16'hC005;
    tick();
    data_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd3) $display("FAIL ppf_cnt: got %0d, required 3", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b1)   $display("FAIL ppf_ov: got %b, required 1", overflow);      else n_pass++;
    n_checks++; if (tx !== 1'b0)         $display("FAIL ppf_tx: got %b, required 0", tx);            else n_pass++;
    frame(16'hC001, "ppf_w1");

    do_reset();
    data_in = 16'hD000; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    for (int k = 1; k <= 2; k++) begin
      data_valid = 1'b1; data_in = 16'hD000 + k[15:0];
      tick();
    end
    data_valid = 1'b0;
    repeat (78) tick();
    n_checks++; if (fifo_count !== 3'd2 || tx !== 1'b1)
      $display("FAIL pp2_pre: cnt=%0d tx=%b, required cnt=2 tx=1", fifo_count, tx);
    else n_pass++;
    data_valid = 1'b1; data_in = 16'hD003;
    tick();
    data_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd2) $display("FAIL pp2_cnt: got %0d, required 2", fifo_count); else n_pass++;
    n_checks++; if (overflow !== 1'b0)   $display("FAIL pp2_ov: got %b, required 0", overflow);      else n_pass++;
    n_checks++; if (tx !== 1'b0)         $display("FAIL pp2_tx: got %b, required 0", tx);            else n_pass++;
    frame(16'hD001, "pp2_w1");
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    data_in = 16'h00F0; data_valid = 1'b1;
    tick();
    data_in = 16'hBEEF;
    tick();
    data_valid = 1'b0;
    repeat (17) tick();
    n_checks++; if (tx !== 1'b0 || fifo_count !== 3'd1)
      $display("FAIL mid_pre: tx=%b cnt=%0d, required tx=0 cnt=1", tx, fifo_count);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1)         $display("FAIL mid_tx: got %b, required 1", tx);            else n_pass++;
    n_checks++; if (fifo_count !== 3'd0) $display("FAIL mid_cnt: got %0d, required 0", fifo_count);  else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL mid_busy: got %b, required 0", busy);        else n_pass++;
    tick(); tick();
    reset = 1'b1;
    tick();
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_post: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
    else n_pass++;
    data_in = 16'h1234; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    n_checks++; if (tx !== 1'b0) $display("FAIL mid_new_start: got %b, required 0", tx); else n_pass++;
    frame(16'h1234, "mid_new");
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_new_busy: got %b, required 0", busy); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; data_in = 16'h0000; data_valid = 1'b0; overflow_clr = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_out_uart_tx.md
Name: cpu_out_uart_tx

Overview:
- Downstream consumer of the CPU's 16-bit data output.
- Captures each word the CPU presents with a valid strobe into a small FIFO, then serializes it on a single UART TX line (8N1, low byte first).
- Decouples single-cycle CPU writes from slow serial output, so the bench and board can observe the program's results on one pin.

Parameters:
- DEPTH, 8, number of 16-bit FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 868, clock cycles per UART bit; minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  16  CPU data_out word.
- data_valid  input  1  push strobe; one word captured per cycle when high.
- overflow_clr  input  1  synchronous clear of the sticky overflow flag.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- fifo_count  output  $clog2(DEPTH)+1  number of words currently queued.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (reset=0, asynchronous): tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers=0. Reset mid-frame aborts the frame immediately; tx returns high and no partial byte resumes.
- FIFO:
  - Push when data_valid=1 and fifo_count<DEPTH.
  - Pop occurs only in FSM IDLE with fifo_count>0.
  - Push and pop in the same cycle: both happen, fifo_count unchanged.
  - Push while full (fifo_count==DEPTH) is dropped, even if a pop happens that cycle, and overflow is set.
  - Pointers wrap modulo DEPTH.
- Overflow flag: overflow_clr=1 clears it. If overflow_clr=1 and a dropped push happen in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP. Byte-select bit hb: 0 = low byte, 1 = high byte.
  - IDLE: tx=1. If fifo_count>0, pop the word into a 16-bit shadow register, set hb=0, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = selected byte[index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then, if hb=0, set hb=1 and go to START with no gap; else go to IDLE.
- tx is driven from a register, so there is no combinational path from inputs.
- Latency: a word pushed at edge N into an empty FIFO with FSM idle is popped at edge N+1. tx falls at edge N+1, and the full frame pair lasts 20*CLKS_PER_BIT cycles.
- Consecutive words are separated by exactly one clock of idle-high tx (the IDLE pop cycle).
- busy = (FSM != IDLE) or (fifo_count != 0). busy is registered consistent with state, so it rises at the push edge.
- The bit counter and baud counter are internal; the baud counter reloads at every state entry.
- data_in is sampled only on accepted pushes. Changes to data_in while data_valid=0 are ignored.

Test Plan:
1. Reset behaviour (DEPTH=4, CLKS_PER_BIT=4): hold reset low, toggle data_valid -> tx=1, busy=0, fifo_count=0, overflow=0 throughout. Release reset -> outputs unchanged.
2. Single word: push 16'hA53C for one cycle -> tx falls on the next edge. Sampled waveform at 4 clocks/bit is 0, 00111100 (LSB first, 0x3C), 1, 0, 10100101 (LSB first, 0xA5), 1. busy falls after 80 cycles; fifo_count returns to 0.
3. Back-to-back: push 16'h0001 and 16'hFFFF on consecutive cycles -> fifo_count peaks at 1. Second frame starts exactly 1 idle-high clock after the first frame's final stop bit, and both words decode correctly.
4. Overflow: with FSM busy, push 6 words (DEPTH=4) -> fifo_count saturates at 4 and overflow=1. Only the first word plus the first 4 queued words are transmitted. overflow stays 1 until an overflow_clr pulse, after which it reads 0.
5. Simultaneous push/pop with full FIFO during the IDLE pop cycle -> push dropped, overflow set, fifo_count goes 4→3. With FIFO at count 2 -> count stays 2.
6. Reset mid-frame: assert reset during the DATA bit 3 of the low byte -> tx=1 immediately and fifo_count=0. A new push after release transmits cleanly from a start bit.
